// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue for the RV32 front end.
// Issues sequential word fetches while credit allows and buffers in-order responses with their PC.
// It presents the head entry to decode.
// A redirect clears the queue and retargets fetch. Responses for fetches that were still in flight
// at the redirect are counted out and discarded when they arrive.
module inst_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        jmp_vld,
  input  logic [31:0] jmp_addr,
  output logic        mem_req_vld,
  input  logic        mem_req_rdy,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_vld,
  input  logic [31:0] mem_resp_data,
  output logic        IF_vld,
  output logic [31:0] IF_pc,
  output logic [31:0] IF_inst
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic [CW:0]   in_use;
  logic          req_fire;
  logic          fifo_empty;
  logic          dropping;
  logic          push;
  logic          pop;
  logic [CW-1:0] outstanding_nxt;
  logic [31:0]   jmp_target;

  // Credit covers both queued entries and fetches still in flight.
  // Every accepted request is therefore guaranteed a free slot when its response lands.
  assign in_use      = {1'b0, fifo_count} + {1'b0, outstanding};
  assign mem_req_vld = !rst && !jmp_vld && (in_use < DEPTH_W);
  assign mem_req_addr = fetch_pc;
  assign req_fire    = mem_req_vld && mem_req_rdy;

  assign fifo_empty = (fifo_count == '0);
  assign IF_vld     = !fifo_empty;
  assign IF_pc      = fifo_empty ? resp_pc  : pc_mem[rd_ptr];
  assign IF_inst    = fifo_empty ? NOP_INST : inst_mem[rd_ptr];

  assign dropping   = (drop_cnt != '0);
  assign push       = mem_resp_vld && !dropping && !jmp_vld && !rst;
  assign pop        = IF_vld && !hold && !jmp_vld;

  assign outstanding_nxt = outstanding + (req_fire ? CNT_ONE : '0) - (mem_resp_vld ? CNT_ONE : '0);
  assign jmp_target      = jmp_addr & ~32'h0000_0003;

  // Pointer, counter and PC bookkeeping; redirect overrides normal queue traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      fifo_count  <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (jmp_vld) begin
      fetch_pc    <= jmp_target;
      resp_pc     <= jmp_target;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= outstanding_nxt;
      // Every fetch still in flight after this cycle belongs to the old stream.
      drop_cnt    <= outstanding_nxt;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding_nxt;
      if (mem_resp_vld && dropping) begin
        drop_cnt <= drop_cnt - CNT_ONE;
      end
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        wr_ptr  <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      fifo_count <= fifo_count + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
    end
  end

  // Entry storage; contents are only meaningful under fifo_count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      inst_mem[wr_ptr] <= mem_resp_data;
    end
  end

endmodule
